// File: rtl/ap_pkg.sv
// Shared definitions for the AP instruction path.
// Holds the instruction-cache FSM states, bytes per instruction and the page helper.
package ap_pkg;

   typedef enum logic [1:0] {
      FILL_REQ,
      FILL_WAIT,
      READY
   } ins_cache_st_t;

   localparam int ISA_BYTES = 8;

   function automatic logic [31:0] page_of(
      input logic [31:0] addr,
      input int unsigned lg_depth
   );
      return addr >> lg_depth;
   endfunction

endpackage

// File: rtl/ins_cache_mem.sv
// Page storage for ins_cache: simple dual-port RAM.
// One synchronous write port, one registered read port (1-cycle latency).
module ins_cache_mem #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Read register holds its value when no read is requested
   always_ff @(posedge clk) begin
      if (rst)       o_rdata <= '0;
      else if (i_re) o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/ins_cache.sv
// Page-based instruction cache refilled one word per DDR request.
// Optional INS_CACHE_FILL_CNT_EN adds a saturating completed-fill counter.
module ins_cache
   import ap_pkg::*;
#(
   parameter int ADDR_WIDTH_MEM  = 16,
   parameter int ISA_DEPTH       = 64,
   parameter int TOTAL_ISA_DEPTH = 128,
   parameter int ISA_WIDTH       = 64,
   parameter int DDR_ADDR_WIDTH  = 28,
   parameter int ISA_BASE_ADDR   = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
   output logic [ISA_WIDTH-1:0]      ins,
   output logic                      ins_valid,
   output logic                      ins_cache_inited,
   output logic                      ins_cache_rdy,
   output logic [9:0]                load_times,
   output logic                      ddr_rd_req,
   output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
   input  logic                      ddr_rd_rdy,
   input  logic [ISA_WIDTH-1:0]      ddr_rd_data,
   input  logic                      ddr_rd_data_valid
`ifdef INS_CACHE_FILL_CNT_EN
   ,output logic [15:0]              fill_cnt
`endif
);

   localparam int AW = $clog2(ISA_DEPTH);

   ins_cache_st_t r_state, w_state_nxt;

   logic                      r_req;
   logic [DDR_ADDR_WIDTH-1:0] r_addr;
   logic [AW-1:0]             r_k;
   logic [9:0]                r_page;
   logic [9:0]                r_load;
   logic                      r_inited;
   logic                      r_valid;

   logic [31:0] w_addr32;
   logic [31:0] w_p;
   logic [31:0] w_rem;
   logic [31:0] w_next_addr;
   logic        w_idle;
   logic        w_hit;
   logic        w_miss;
   logic        w_acc;
   logic        w_wr;
   logic        w_last;
   logic        w_done;

   assign w_addr32 = 32'(addr_ins);
   assign w_p      = page_of(w_addr32, AW);
   assign w_idle   = addr_ins[ADDR_WIDTH_MEM-1]
                   || (w_addr32 >= 32'(TOTAL_ISA_DEPTH));
   assign w_hit    = (r_state == READY) && !w_idle
                   && (w_p == 32'(r_page));
   assign w_miss   = (r_state == READY) && !w_idle && !w_hit;
   assign w_acc    = (r_state == FILL_REQ) && r_req && ddr_rd_rdy;
   assign w_wr     = (r_state == FILL_WAIT) && ddr_rd_data_valid;

   // Last word is the page end, or the program end on a partial page
   assign w_rem  = 32'(TOTAL_ISA_DEPTH - 1)
                 - 32'(r_page) * 32'(ISA_DEPTH);
   assign w_last = (r_k == AW'(ISA_DEPTH - 1)) || (32'(r_k) == w_rem);
   assign w_done = w_wr && w_last;

   assign w_next_addr = 32'(ISA_BASE_ADDR)
      + (32'(r_page) * 32'(ISA_DEPTH) + 32'(r_k)) * 32'(ISA_BYTES);

   always_ff @(posedge clk) begin
      if (rst) r_state <= FILL_REQ;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         FILL_REQ:  if (w_acc) w_state_nxt = FILL_WAIT;
         FILL_WAIT: if (w_wr)  w_state_nxt = w_last ? READY : FILL_REQ;
         READY:     if (w_miss) w_state_nxt = FILL_REQ;
         default:   w_state_nxt = FILL_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_req    <= 1'b0;
         r_addr   <= '0;
         r_k      <= '0;
         r_page   <= '0;
         r_load   <= '0;
         r_inited <= 1'b0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= w_hit;
         if ((r_state == FILL_REQ) && !r_req) begin
            r_req  <= 1'b1;
            r_addr <= DDR_ADDR_WIDTH'(w_next_addr);
         end else if (w_acc) begin
            r_req <= 1'b0;
         end
         if (w_wr) r_k <= r_k + 1'b1;
         if (w_done) begin
            r_load   <= r_page + 10'd1;
            r_inited <= 1'b1;
         end
         if (w_miss) begin
            r_page <= 10'(w_p);
            r_k    <= '0;
         end
      end
   end

`ifdef INS_CACHE_FILL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)                          fill_cnt <= '0;
      else if (w_done && ~&fill_cnt)    fill_cnt <= fill_cnt + 16'd1;
   end
`endif

   ins_cache_mem #(
      .DEPTH (ISA_DEPTH),
      .WIDTH (ISA_WIDTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_wr),
      .i_waddr (r_k),
      .i_wdata (ddr_rd_data),
      .i_re    (w_hit),
      .i_raddr (addr_ins[AW-1:0]),
      .o_rdata (ins)
   );

   assign ins_valid        = r_valid;
   assign ins_cache_inited = r_inited;
   assign ins_cache_rdy    = w_hit && !rst;
   assign load_times       = r_load;
   assign ddr_rd_req       = r_req;
   assign ddr_rd_addr      = r_addr;

endmodule

// File: tb/tb_ins_cache.sv
// Directed bench for ins_cache with a 2-cycle-latency DDR responder.
// Program length is 100 so the second page is a partial one.
module tb_ins_cache;

   localparam int TOTAL = 100;

   logic        clk;
   logic        rst;
   logic [15:0] addr_ins;
   logic [63:0] ins;
   logic        ins_valid;
   logic        ins_cache_inited;
   logic        ins_cache_rdy;
   logic [9:0]  load_times;
   logic        ddr_rd_req;
   logic [27:0] ddr_rd_addr;
   logic        ddr_rd_rdy;
   logic [63:0] ddr_rd_data;
   logic        ddr_rd_data_valid;
`ifdef INS_CACHE_FILL_CNT_EN
   logic [15:0] fill_cnt;
`endif

   int n_checks;
   int n_fail;

   ins_cache #(
      .ADDR_WIDTH_MEM  (16),
      .ISA_DEPTH       (64),
      .TOTAL_ISA_DEPTH (TOTAL),
      .ISA_WIDTH       (64),
      .DDR_ADDR_WIDTH  (28),
      .ISA_BASE_ADDR   (0)
   ) u_dut (
      .clk               (clk),
      .rst               (rst),
      .addr_ins          (addr_ins),
      .ins               (ins),
      .ins_valid         (ins_valid),
      .ins_cache_inited  (ins_cache_inited),
      .ins_cache_rdy     (ins_cache_rdy),
      .load_times        (load_times),
      .ddr_rd_req        (ddr_rd_req),
      .ddr_rd_addr       (ddr_rd_addr),
      .ddr_rd_rdy        (ddr_rd_rdy),
      .ddr_rd_data       (ddr_rd_data),
      .ddr_rd_data_valid (ddr_rd_data_valid)
`ifdef INS_CACHE_FILL_CNT_EN
      ,.fill_cnt         (fill_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] wd(input int i);
      return {32'hC0DE_0000 | 32'(i), 32'h0BAD_F00D ^ 32'(i)};
   endfunction

   // DDR responder: accepts a request, returns its word two cycles later
   int          acc_cnt;
   int          rsp_cnt;
   logic [27:0] acc_q[$];
   logic [27:0] acc_addr;
   logic [27:0] pend_addr;
   bit          pend;
   int          dly;

   initial begin
      ddr_rd_rdy        = 1'b0;
      ddr_rd_data       = '0;
      ddr_rd_data_valid = 1'b0;
      acc_cnt = 0;
      rsp_cnt = 0;
      pend    = 1'b0;
      dly     = 0;
   end

   always @(negedge clk) begin
      ddr_rd_data_valid = 1'b0;
      if (rst) begin
         pend       = 1'b0;
         ddr_rd_rdy = 1'b0;
      end else begin
         if (ddr_rd_rdy) begin
            pend       = 1'b1;
            dly        = 2;
            pend_addr  = acc_addr;
            ddr_rd_rdy = 1'b0;
         end else if (ddr_rd_req && !pend) begin
            ddr_rd_rdy = 1'b1;
            acc_addr   = ddr_rd_addr;
            acc_q.push_back(ddr_rd_addr);
            acc_cnt++;
         end
         if (pend) begin
            dly--;
            if (dly == 0) begin
               ddr_rd_data       = wd(int'(pend_addr >> 3));
               ddr_rd_data_valid = 1'b1;
               pend              = 1'b0;
               rsp_cnt++;
            end
         end
      end
   end

   task automatic wait_ready(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(posedge clk);
         #1;
         if (ins_cache_rdy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst      = 1'b1;
      addr_ins = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (ins !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_ins got %h want 0", ins);
      end
      n_checks++;
      if (ins_valid !== 1'b0 || ins_cache_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid_rdy got %b%b want 00",
                  ins_valid, ins_cache_rdy);
      end
      n_checks++;
      if (ins_cache_inited !== 1'b0 || load_times !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_init_load got %b/%0d want 0/0",
                  ins_cache_inited, load_times);
      end
      n_checks++;
      if (ddr_rd_req !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_req got %b want 0", ddr_rd_req);
      end
`ifdef INS_CACHE_FILL_CNT_EN
      n_checks++;
      if (fill_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_fill_cnt got %0d want 0", fill_cnt);
      end
`endif
   endtask

   task automatic test_first_fill;
      bit ok;
      int bad;
      acc_q.delete();
      @(negedge clk);
      rst = 1'b0;
      wait_ready(2000, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL fill0_timeout got rdy=0 want rdy=1");
      end
      n_checks++;
      if (acc_q.size() != 64) begin
         n_fail++;
         $display("FAIL fill0_count got %0d want 64", acc_q.size());
      end
      bad = 0;
      foreach (acc_q[i])
         if (acc_q[i] !== 28'(i * 8)) bad++;
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL fill0_addr got %0d wrong addresses want 0", bad);
      end
      n_checks++;
      if (ins_cache_inited !== 1'b1 || load_times !== 10'd1) begin
         n_fail++;
         $display("FAIL fill0_state got %b/%0d want 1/1",
                  ins_cache_inited, load_times);
      end
`ifdef INS_CACHE_FILL_CNT_EN
      n_checks++;
      if (fill_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL fill0_cnt got %0d want 1", fill_cnt);
      end
`endif
   endtask

   task automatic test_hit;
      @(negedge clk);
      addr_ins = 16'd5;
      @(posedge clk);
      #1;
      n_checks++;
      if (ins !== wd(5) || ins_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL hit5 got %h/%b want %h/1", ins, ins_valid, wd(5));
      end
      @(negedge clk);
      addr_ins = 16'd63;
      @(posedge clk);
      #1;
      n_checks++;
      if (ins !== wd(63) || ins_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL hit63 got %h/%b want %h/1", ins, ins_valid, wd(63));
      end
   endtask

   task automatic test_idle;
      @(negedge clk);
      addr_ins = 16'h8000;
      #1;
      n_checks++;
      if (ins_cache_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_rdy got %b want 0", ins_cache_rdy);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (ins_valid !== 1'b0 || ins !== wd(63)) begin
         n_fail++;
         $display("FAIL idle_hold got %h/%b want %h/0", ins, ins_valid, wd(63));
      end
   endtask

   task automatic test_page_miss;
      bit ok;
      acc_q.delete();
      @(negedge clk);
      addr_ins = 16'd64;
      #1;
      n_checks++;
      if (ins_cache_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL miss_rdy got %b want 0", ins_cache_rdy);
      end
      wait_ready(1500, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL miss_timeout got rdy=0 want rdy=1");
      end
      n_checks++;
      if (acc_q.size() != 36) begin
         n_fail++;
         $display("FAIL miss_count got %0d want 36", acc_q.size());
      end else begin
         n_checks++;
         if (acc_q[0] !== 28'h200 || acc_q[35] !== 28'h318) begin
            n_fail++;
            $display("FAIL miss_addr got %h..%h want 200..318",
                     acc_q[0], acc_q[35]);
         end
      end
      n_checks++;
      if (load_times !== 10'd2) begin
         n_fail++;
         $display("FAIL miss_load got %0d want 2", load_times);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (ins !== wd(64) || ins_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL miss_ins got %h/%b want %h/1", ins, ins_valid, wd(64));
      end
   endtask

   task automatic test_out_of_range;
      int base;
      @(negedge clk);
      addr_ins = 16'd100;
      base = acc_cnt;
      repeat (10) @(posedge clk);
      #1;
      n_checks++;
      if (ins_cache_rdy !== 1'b0 || ins_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL oob_rdy got %b/%b want 0/0", ins_cache_rdy, ins_valid);
      end
      n_checks++;
      if (acc_cnt != base || ddr_rd_req !== 1'b0) begin
         n_fail++;
         $display("FAIL oob_req got %0d reqs want 0", acc_cnt - base);
      end
      @(negedge clk);
      addr_ins = 16'd99;
      @(posedge clk);
      #1;
      n_checks++;
      if (ins !== wd(99) || ins_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL last_ins got %h/%b want %h/1", ins, ins_valid, wd(99));
      end
   endtask

   task automatic test_jump;
      bit ok;
      int base;
      @(negedge clk);
      addr_ins = 16'h8000;
      base = acc_cnt;
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (acc_cnt != base) begin
         n_fail++;
         $display("FAIL jump_msb got %0d reqs want 0", acc_cnt - base);
      end
      @(negedge clk);
      acc_q.delete();
      addr_ins = 16'd3;
      wait_ready(2000, ok);
      n_checks++;
      if (!ok || acc_q.size() != 64) begin
         n_fail++;
         $display("FAIL jump_fill got ok=%b n=%0d want ok=1 n=64",
                  ok, acc_q.size());
      end else begin
         n_checks++;
         if (acc_q[0] !== 28'h0 || acc_q[63] !== 28'h1F8) begin
            n_fail++;
            $display("FAIL jump_addr got %h..%h want 0..1f8",
                     acc_q[0], acc_q[63]);
         end
      end
      n_checks++;
      if (load_times !== 10'd1) begin
         n_fail++;
         $display("FAIL jump_load got %0d want 1", load_times);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (ins !== wd(3) || ins_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL jump_ins got %h/%b want %h/1", ins, ins_valid, wd(3));
      end
   endtask

   task automatic test_reset_midfill;
      bit ok;
      int base;
      @(negedge clk);
      addr_ins = 16'd64;
      base = rsp_cnt;
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         #1;
         if (rsp_cnt - base >= 10) begin
            ok = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL midfill_timeout got %0d words want 10", rsp_cnt - base);
      end
      @(negedge clk);
      rst      = 1'b1;
      addr_ins = 16'd0;
      @(posedge clk);
      #1;
      n_checks++;
      if (ddr_rd_req !== 1'b0 || ins_cache_inited !== 1'b0) begin
         n_fail++;
         $display("FAIL midfill_rst got req=%b init=%b want 0/0",
                  ddr_rd_req, ins_cache_inited);
      end
`ifdef INS_CACHE_FILL_CNT_EN
      n_checks++;
      if (fill_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL midfill_cnt_rst got %0d want 0", fill_cnt);
      end
`endif
      @(negedge clk);
      acc_q.delete();
      rst = 1'b0;
      wait_ready(2000, ok);
      n_checks++;
      if (!ok || acc_q.size() != 64) begin
         n_fail++;
         $display("FAIL refill got ok=%b n=%0d want ok=1 n=64",
                  ok, acc_q.size());
      end else begin
         n_checks++;
         if (acc_q[0] !== 28'h0) begin
            n_fail++;
            $display("FAIL refill_addr got %h want 0", acc_q[0]);
         end
      end
      n_checks++;
      if (load_times !== 10'd1 || ins_cache_inited !== 1'b1) begin
         n_fail++;
         $display("FAIL refill_state got %0d/%b want 1/1",
                  load_times, ins_cache_inited);
      end
`ifdef INS_CACHE_FILL_CNT_EN
      n_checks++;
      if (fill_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL refill_cnt got %0d want 1", fill_cnt);
      end
`endif
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_first_fill();
      test_hit();
      test_idle();
      test_page_miss();
      test_out_of_range();
      test_jump();
      test_reset_midfill();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
